// File: rtl/frog_pkg.sv
// frog_pkg: shared definitions for the frog controller and the sprite renderer.
// Holds direction encodings, the controller FSM state type, screen/sprite
// defaults and small position helpers used by frog_controller.
package frog_pkg;

  localparam int SCREEN_W_DEFAULT  = 640;
  localparam int SCREEN_H_DEFAULT  = 480;
  localparam int FROG_SIZE_DEFAULT = 32;

  // Output position width and the signed width used for move arithmetic.
  localparam int POS_W  = 10;
  localparam int POS_SW = 11;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOP     = 2'd1,
    RESPAWN = 2'd2
  } frog_state_e;

  // Signed top-left position; one spare bit so a step off the screen edge
  // shows up as negative (or past the limit) instead of wrapping.
  typedef struct packed {
    logic signed [POS_SW-1:0] x;
    logic signed [POS_SW-1:0] y;
  } pos_s_t;

  // Position after moving amt pixels in direction d (screen y grows downward).
  function automatic pos_s_t move_pos(pos_s_t p, dir_e d, logic signed [POS_SW-1:0] amt);
    pos_s_t r;
    r = p;
    case (d)
      DIR_UP:    r.y = p.y - amt;
      DIR_DOWN:  r.y = p.y + amt;
      DIR_LEFT:  r.x = p.x - amt;
      DIR_RIGHT: r.x = p.x + amt;
    endcase
    return r;
  endfunction

  // True when the sprite's top-left stays inside [0,max_x] x [0,max_y].
  function automatic logic pos_in_bounds(pos_s_t p,
                                         logic signed [POS_SW-1:0] max_x,
                                         logic signed [POS_SW-1:0] max_y);
    return (p.x >= 0) && (p.x <= max_x) && (p.y >= 0) && (p.y <= max_y);
  endfunction

endpackage

// File: rtl/frog_button_debounce.sv
// frog_button_debounce: 2-flop synchroniser for one raw button, a frame-rate
// debounce counter and a single-cycle press pulse. The pulse fires on the
// frame_tick where the counter reaches DEBOUNCE_FRAMES; holding the button
// keeps the counter saturated so it never repeats, and a low frame re-arms it.
module frog_button_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [1:0]       sync_q;
  logic             btn_sync;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous button into the clk domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign btn_sync = sync_q[1];

  // Count consecutive frames the button reads high, saturating at the threshold.
  // NOTE: cnt_d gets its default first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (frame_tick_i) begin
      if (!btn_sync) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The press is the tick on which the counter steps onto the threshold.
  assign press_o = frame_tick_i & btn_sync & (cnt_q == CNT_ARM);

endmodule

// File: rtl/frog_controller.sv
// frog_controller: frog position/direction controller for a Frogger-style game.
// Buttons are debounced at frame rate; the IDLE/HOP/RESPAWN FSM only moves on
// frame_tick and its registered outputs are valid the clk after that tick.
// Build option: define FROG_SMOOTH_HOP_EN for a 4-frame hop of STEP/4 pixels
// per frame; without it a hop completes in a single frame.
module frog_controller
  import frog_pkg::*;
#(
  parameter int SCREEN_W        = SCREEN_W_DEFAULT,
  parameter int SCREEN_H        = SCREEN_H_DEFAULT,
  parameter int FROG_SIZE       = FROG_SIZE_DEFAULT,
  parameter int STEP            = 32,
  parameter int START_X         = 304,
  parameter int START_Y         = 448,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int RESPAWN_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       collision,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [1:0] direction,
  output logic       hopping,
  output logic       goal,
  output logic       dead
);

`ifdef FROG_SMOOTH_HOP_EN
  localparam int HOP_TICKS = 4;
`else
  localparam int HOP_TICKS = 1;
`endif

  localparam int HOP_PX = STEP / HOP_TICKS;

  localparam logic signed [POS_SW-1:0] STEP_S   = POS_SW'(STEP);
  localparam logic signed [POS_SW-1:0] HOP_PX_S = POS_SW'(HOP_PX);
  localparam logic signed [POS_SW-1:0] MAX_X_S  = POS_SW'(SCREEN_W - FROG_SIZE);
  localparam logic signed [POS_SW-1:0] MAX_Y_S  = POS_SW'(SCREEN_H - FROG_SIZE);
  localparam logic [POS_W-1:0]         SPAWN_X  = POS_W'(START_X);
  localparam logic [POS_W-1:0]         SPAWN_Y  = POS_W'(START_Y);

  localparam int               RCNT_W    = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [RCNT_W-1:0] RESP_LAST = RCNT_W'(RESPAWN_FRAMES - 1);

  // Debounced press pulses, one per button.
  logic press_up;
  logic press_down;
  logic press_left;
  logic press_right;
  logic any_press;

  frog_button_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_up (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .btn_i        (btn_up),
    .press_o      (press_up)
  );

  frog_button_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_down (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .btn_i        (btn_down),
    .press_o      (press_down)
  );

  frog_button_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_left (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .btn_i        (btn_left),
    .press_o      (press_left)
  );

  frog_button_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_right (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .btn_i        (btn_right),
    .press_o      (press_right)
  );

  assign any_press = press_up | press_down | press_left | press_right;

  // State and registered outputs.
  frog_state_e       state_q,    state_d;
  logic [POS_W-1:0]  x_q,        x_d;
  logic [POS_W-1:0]  y_q,        y_d;
  dir_e              dir_q,      dir_d;
  logic              hopping_q,  hopping_d;
  logic              goal_q,     goal_d;
  logic              dead_q,     dead_d;
  logic [RCNT_W-1:0] resp_cnt_q, resp_cnt_d;
  logic              hop_last;

`ifdef FROG_SMOOTH_HOP_EN
  logic [1:0] hop_cnt_q, hop_cnt_d;

  assign hop_last = (hop_cnt_q == 2'd3);

  // Frame counter within a smooth hop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hop_cnt_q <= '0;
    end else begin
      hop_cnt_q <= hop_cnt_d;
    end
  end
`else
  assign hop_last = 1'b1;
`endif

  // Move geometry: current position, the full-step target of a new press
  // and the next in-flight position of a running hop.
  pos_s_t cur_pos;
  pos_s_t press_tgt;
  pos_s_t hop_nxt;
  dir_e   press_dir;
  logic   press_ok;

  assign cur_pos = '{x: $signed({1'b0, x_q}), y: $signed({1'b0, y_q})};

  // Resolve simultaneous presses: up > down > left > right.
  always_comb begin
    press_dir = DIR_RIGHT;
    if (press_up) begin
      press_dir = DIR_UP;
    end else if (press_down) begin
      press_dir = DIR_DOWN;
    end else if (press_left) begin
      press_dir = DIR_LEFT;
    end
  end

  assign press_tgt = move_pos(cur_pos, press_dir, STEP_S);
  assign press_ok  = pos_in_bounds(press_tgt, MAX_X_S, MAX_Y_S);
  assign hop_nxt   = move_pos(cur_pos, dir_q, HOP_PX_S);

  // FSM next state and output updates; nothing changes except on frame_tick.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    hopping_d  = hopping_q;
    goal_d     = 1'b0;
    dead_d     = dead_q;
    resp_cnt_d = resp_cnt_q;
`ifdef FROG_SMOOTH_HOP_EN
    hop_cnt_d  = hop_cnt_q;
`endif

    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (collision) begin
            state_d    = RESPAWN;
            dead_d     = 1'b1;
            hopping_d  = 1'b0;
            resp_cnt_d = '0;
          end else if (any_press) begin
            // Facing follows the press even when the move is off-screen.
            dir_d = press_dir;
            if (press_ok) begin
              state_d   = HOP;
              hopping_d = 1'b1;
`ifdef FROG_SMOOTH_HOP_EN
              hop_cnt_d = '0;
`endif
            end
          end
        end

        HOP: begin
          if (collision) begin
            // A hit freezes the frog where it is and outranks a goal.
            state_d    = RESPAWN;
            dead_d     = 1'b1;
            hopping_d  = 1'b0;
            resp_cnt_d = '0;
          end else begin
            x_d = POS_W'(hop_nxt.x);
            y_d = POS_W'(hop_nxt.y);
            if (hop_last) begin
              hopping_d = 1'b0;
              if (hop_nxt.y == '0) begin
                state_d    = RESPAWN;
                goal_d     = 1'b1;
                resp_cnt_d = '0;
              end else begin
                state_d = IDLE;
              end
            end
`ifdef FROG_SMOOTH_HOP_EN
            else begin
              hop_cnt_d = hop_cnt_q + 2'd1;
            end
`endif
          end
        end

        RESPAWN: begin
          if (resp_cnt_q == RESP_LAST) begin
            state_d    = IDLE;
            x_d        = SPAWN_X;
            y_d        = SPAWN_Y;
            dir_d      = DIR_UP;
            dead_d     = 1'b0;
            resp_cnt_d = '0;
          end else begin
            resp_cnt_d = resp_cnt_q + RCNT_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register; reset drops any hop in flight back to the spawn point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= SPAWN_X;
      y_q        <= SPAWN_Y;
      dir_q      <= DIR_UP;
      hopping_q  <= 1'b0;
      goal_q     <= 1'b0;
      dead_q     <= 1'b0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      hopping_q  <= hopping_d;
      goal_q     <= goal_d;
      dead_q     <= dead_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  assign frog_x    = x_q;
  assign frog_y    = y_q;
  assign direction = dir_q;
  assign hopping   = hopping_q;
  assign goal      = goal_q;
  assign dead      = dead_q;

endmodule

// File: tb/tb_frog_controller.sv
// tb_frog_controller: directed bench for frog_controller in its default build
// (single-frame hop). dut1 uses the default spawn 304/448; dut2 spawns at
// 0/32 to reach the left edge and the goal row quickly.
module tb_frog_controller;

  localparam logic [3:0] B0 = 4'b0000;
  localparam logic [3:0] BU = 4'b1000;
  localparam logic [3:0] BD = 4'b0100;
  localparam logic [3:0] BL = 4'b0010;
  localparam logic [3:0] BR = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       collision = 1'b0;
  logic [9:0] frog_x, frog_y;
  logic [1:0] direction;
  logic       hopping, goal, dead;

  logic       btn_up2 = 1'b0, btn_down2 = 1'b0, btn_left2 = 1'b0, btn_right2 = 1'b0;
  logic       collision2 = 1'b0;
  logic [9:0] frog_x2, frog_y2;
  logic [1:0] direction2;
  logic       hopping2, goal2, dead2;

  int   n_vec = 0;
  int   n_miss = 0;
  int   goal1_cycles = 0;
  int   goal2_cycles = 0;
  int   hop2_cycles = 0;
  logic goal1_tick = 1'b0;
  logic goal2_tick = 1'b0;

  typedef struct {
    logic [3:0] btn;
    logic       col;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
    logic       hop;
    logic       dead;
  } vec_t;

  vec_t vecs[$];

  frog_controller dut1 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .collision  (collision),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .direction  (direction),
    .hopping    (hopping),
    .goal       (goal),
    .dead       (dead)
  );

  frog_controller #(.START_X(0), .START_Y(32)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up2),
    .btn_down   (btn_down2),
    .btn_left   (btn_left2),
    .btn_right  (btn_right2),
    .collision  (collision2),
    .frog_x     (frog_x2),
    .frog_y     (frog_y2),
    .direction  (direction2),
    .hopping    (hopping2),
    .goal       (goal2),
    .dead       (dead2)
  );

  always #5 clk = ~clk;

  // Pulse-width and "never asserted" monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (goal)     goal1_cycles++;
    if (goal2)    goal2_cycles++;
    if (hopping2) hop2_cycles++;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic c, input int x, input int y,
                     input int d, input logic h, input logic dd);
    vec_t v;
    v.btn  = b;
    v.col  = c;
    v.x    = 10'(x);
    v.y    = 10'(y);
    v.dir  = 2'(d);
    v.hop  = h;
    v.dead = dd;
    vecs.push_back(v);
  endtask

  // Drive buttons/collision, let the synchronisers settle, then give one
  // frame_tick. Returns on the falling edge right after the tick was taken.
  task automatic tick(input logic [3:0] b1, input logic c1, input logic [3:0] b2, input logic c2);
    {btn_up, btn_down, btn_left, btn_right}     = b1;
    collision                                    = c1;
    {btn_up2, btn_down2, btn_left2, btn_right2} = b2;
    collision2                                   = c2;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    goal1_tick = goal;
    goal2_tick = goal2;
  endtask

  initial begin
    // ---- vector table for dut1: inputs for one frame, outputs after it ----
    for (int i = 0; i < 10; i++) add(B0, 0, 304, 448, 0, 0, 0);
    // Up held 5 frames: one hop on the 3rd debounced frame, no repeat.
    add(BU, 0, 304, 448, 0, 0, 0);
    add(BU, 0, 304, 448, 0, 0, 0);
    add(BU, 0, 304, 448, 0, 1, 0);
    add(BU, 0, 304, 416, 0, 0, 0);
    add(BU, 0, 304, 416, 0, 0, 0);
    add(B0, 0, 304, 416, 0, 0, 0);
    // Up and right together: up wins.
    add(BU | BR, 0, 304, 416, 0, 0, 0);
    add(BU | BR, 0, 304, 416, 0, 0, 0);
    add(BU | BR, 0, 304, 416, 0, 1, 0);
    add(BU | BR, 0, 304, 384, 0, 0, 0);
    add(B0,      0, 304, 384, 0, 0, 0);
    // Right, left and down hops.
    add(BR, 0, 304, 384, 0, 0, 0);
    add(BR, 0, 304, 384, 0, 0, 0);
    add(BR, 0, 304, 384, 1, 1, 0);
    add(BR, 0, 336, 384, 1, 0, 0);
    add(B0, 0, 336, 384, 1, 0, 0);
    add(BL, 0, 336, 384, 1, 0, 0);
    add(BL, 0, 336, 384, 1, 0, 0);
    add(BL, 0, 336, 384, 3, 1, 0);
    add(BL, 0, 304, 384, 3, 0, 0);
    add(B0, 0, 304, 384, 3, 0, 0);
    add(BD, 0, 304, 384, 3, 0, 0);
    add(BD, 0, 304, 384, 3, 0, 0);
    add(BD, 0, 304, 384, 2, 1, 0);
    add(BD, 0, 304, 416, 2, 0, 0);
    add(B0, 0, 304, 416, 2, 0, 0);
    // Left hop started, collision on the move frame: frozen and dead.
    add(BL, 0, 304, 416, 2, 0, 0);
    add(BL, 0, 304, 416, 2, 0, 0);
    add(BL, 0, 304, 416, 3, 1, 0);
    add(B0, 1, 304, 416, 3, 0, 1);
    // Respawn wait: presses and a collision are ignored; up held across the
    // respawn point must not hop afterwards.
    for (int k = 1; k <= 29; k++)
      add((k <= 4 || k >= 27) ? BU : B0, (k == 10), 304, 416, 3, 0, 1);
    add(BU, 0, 304, 448, 0, 0, 0);
    add(BU, 0, 304, 448, 0, 0, 0);
    add(B0, 0, 304, 448, 0, 0, 0);
    // Down from the bottom row is rejected but turns the frog.
    add(BD, 0, 304, 448, 0, 0, 0);
    add(BD, 0, 304, 448, 0, 0, 0);
    add(BD, 0, 304, 448, 2, 0, 0);
    add(BD, 0, 304, 448, 2, 0, 0);
    add(B0, 0, 304, 448, 2, 0, 0);

    // ---- reset ----
    repeat (3) @(negedge clk);
    check("rst.x", frog_x, 304);
    check("rst.y", frog_y, 448);
    check("rst.dir", direction, 0);
    check("rst.hop", hopping, 0);
    check("rst.goal", goal, 0);
    check("rst.dead", dead, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].btn, vecs[i].col, B0, 1'b0);
      check($sformatf("v%0d.x", i),    frog_x,    vecs[i].x);
      check($sformatf("v%0d.y", i),    frog_y,    vecs[i].y);
      check($sformatf("v%0d.dir", i),  direction, vecs[i].dir);
      check($sformatf("v%0d.hop", i),  hopping,   vecs[i].hop);
      check($sformatf("v%0d.dead", i), dead,      vecs[i].dead);
    end

    // ---- dut2: left press at x=0 is rejected ----
    tick(B0, 0, BL, 0);
    tick(B0, 0, BL, 0);
    tick(B0, 0, BL, 0);
    check("edge.dir", direction2, 3);
    check("edge.x", frog_x2, 0);
    check("edge.y", frog_y2, 32);
    check("edge.hop", hopping2, 0);
    tick(B0, 0, BL, 0);
    check("edge.x_hold", frog_x2, 0);
    tick(B0, 0, B0, 0);
    check("edge.hop_never", hop2_cycles, 0);

    // ---- dut2: hop from y=32 to y=0 pulses goal, then respawns ----
    tick(B0, 0, BU, 0);
    tick(B0, 0, BU, 0);
    tick(B0, 0, BU, 0);
    check("goal.hop", hopping2, 1);
    check("goal.dir", direction2, 0);
    tick(B0, 0, BU, 0);
    check("goal.y", frog_y2, 0);
    check("goal.pulse", goal2_tick, 1);
    check("goal.dead", dead2, 0);
    check("goal.hop_end", hopping2, 0);
    @(negedge clk);
    check("goal.pulse_end", goal2, 0);
    for (int k = 1; k <= 29; k++) tick(B0, 0, B0, 0);
    check("goal.wait_y", frog_y2, 0);
    check("goal.wait_dead", dead2, 0);
    tick(B0, 0, B0, 0);
    check("goal.spawn_x", frog_x2, 0);
    check("goal.spawn_y", frog_y2, 32);
    check("goal.spawn_dir", direction2, 0);
    check("goal.width", goal2_cycles, 1);

    // ---- dut2: collision on the goal frame wins ----
    tick(B0, 0, BU, 0);
    tick(B0, 0, BU, 0);
    tick(B0, 0, BU, 0);
    check("cg.hop", hopping2, 1);
    tick(B0, 0, BU, 1);
    check("cg.dead", dead2, 1);
    check("cg.y", frog_y2, 32);
    check("cg.goal", goal2_tick, 0);
    check("cg.hop_end", hopping2, 0);
    check("cg.goal_count", goal2_cycles, 1);

    // ---- dut1: reset asserted mid-hop ----
    tick(BU, 0, B0, 0);
    tick(BU, 0, B0, 0);
    tick(BU, 0, B0, 0);
    tick(BU, 0, B0, 0);
    check("mr.y_first", frog_y, 416);
    tick(B0, 0, B0, 0);
    tick(BU, 0, B0, 0);
    tick(BU, 0, B0, 0);
    tick(BU, 0, B0, 0);
    check("mr.hop", hopping, 1);
    check("mr.y_pre", frog_y, 416);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mr.x", frog_x, 304);
    check("mr.y", frog_y, 448);
    check("mr.hop_rst", hopping, 0);
    check("mr.dir", direction, 0);
    check("mr.dead", dead, 0);
    check("mr.dead2", dead2, 0);
    check("mr.y2", frog_y2, 32);
    @(negedge clk);
    rst = 1'b0;
    tick(B0, 0, B0, 0);
    check("mr.after_y", frog_y, 448);
    check("mr.after_hop", hopping, 0);
    check("goal1.never", goal1_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
